// File: rtl/hazard_unit_pkg.sv
// Shared types and constants for the forwarding / interlock / flush controller.
// Scoreboard rd is stored zero-extended to RA_MAX bits so one entry type serves any RA_W <= RA_MAX.
package hazard_unit_pkg;

   localparam int RA_MAX   = 8;

   localparam int FL_IFID  = 0;
   localparam int FL_IDEX  = 1;
   localparam int FL_EXMEM = 2;

   typedef struct packed {
      logic              valid;
      logic [RA_MAX-1:0] rd;
      logic              regwrite;
      logic              memread;
   } sb_entry_t;

   function automatic int sel_w(input int stages);
      return $clog2(stages + 1);
   endfunction

endpackage

// File: rtl/hazard_match.sv
// Priority match of one source register against a scoreboard slice; sel = 1 + index of the
// youngest (lowest-index) matching producer, 0 when nothing matches.
module hazard_match
   import hazard_unit_pkg::*;
#(
   parameter int  RA_W            = 5,
   parameter int  NENT            = 2,
   parameter int  SKIP_LOAD_BELOW = 0,
   localparam int SELW            = $clog2(NENT + 1)
) (
   input  logic [RA_W-1:0]      rs,
   input  logic                 rs_used,
   input  sb_entry_t [NENT-1:0] ents,
   output logic [SELW-1:0]      sel
);

   // Scan oldest to youngest so the youngest hit overwrites; loads whose data is not yet
   // available (index below SKIP_LOAD_BELOW) are not candidates at all.
   always_comb begin
      sel = '0;
      for (int k = NENT - 1; k >= 0; k--) begin
         if (rs_used && (rs != '0) && ents[k].valid && ents[k].regwrite
             && (ents[k].rd == RA_MAX'(rs))
             && !(ents[k].memread && (k < SKIP_LOAD_BELOW)))
            sel = SELW'(k + 1);
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// Forwarding select, load-use interlock and branch flush controller for the in-order core.
// Scoreboard entry s0 is the instruction in EX; s1..sF are the stages behind it.
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int  RA_W       = 5,
   parameter int  NUM_SRC    = 2,
   parameter int  FWD_STAGES = 2,
   parameter int  LOAD_LAT   = 1,
   parameter int  BR_STAGE   = 1,
   parameter int  CNT_W      = 32,
   localparam int SW         = sel_w(FWD_STAGES)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    id_valid,
   input  logic [NUM_SRC*RA_W-1:0] id_rs,
   input  logic [NUM_SRC-1:0]      id_rs_used,
   input  logic [RA_W-1:0]         id_rd,
   input  logic                    id_regwrite,
   input  logic                    id_memread,
   input  logic                    br_taken,
   output logic [NUM_SRC*SW-1:0]   fwd_sel,
   output logic                    stall,
   output logic [BR_STAGE+1:0]     flush,
   output logic [CNT_W-1:0]        stall_cnt
);

   localparam int STW = sel_w(FWD_STAGES + 1);

   sb_entry_t [FWD_STAGES:0] sb_q, sb_d;
   logic [NUM_SRC*RA_W-1:0]  ex_rs_q, ex_rs_d;
   logic [NUM_SRC-1:0]       ex_used_q, ex_used_d;
   logic [CNT_W-1:0]         stall_cnt_q, stall_cnt_d;
   logic [SW-1:0]            fwd_raw [NUM_SRC];
   logic [STW-1:0]           st_sel  [NUM_SRC];
   logic                     stall_raw;
   logic                     id_load;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      hazard_match #(
         .RA_W(RA_W), .NENT(FWD_STAGES), .SKIP_LOAD_BELOW(LOAD_LAT)
      ) u_fwd (
         .rs(ex_rs_q[i*RA_W +: RA_W]), .rs_used(ex_used_q[i]),
         .ents(sb_q[FWD_STAGES:1]), .sel(fwd_raw[i])
      );

      hazard_match #(
         .RA_W(RA_W), .NENT(FWD_STAGES + 1), .SKIP_LOAD_BELOW(0)
      ) u_stall (
         .rs(id_rs[i*RA_W +: RA_W]), .rs_used(id_rs_used[i]),
         .ents(sb_q), .sel(st_sel[i])
      );
   end

   // Stall only when the youngest producer of a used ID source is a load still inside its latency window.
   always_comb begin
      stall_raw = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         for (int j = 0; j < LOAD_LAT; j++) begin
            if ((st_sel[i] == STW'(j + 1)) && sb_q[j].memread)
               stall_raw = 1'b1;
         end
      end
      stall = stall_raw && !br_taken && !rst;
      flush = {(BR_STAGE + 2){br_taken && !rst}};
      fwd_sel = '0;
      for (int i = 0; i < NUM_SRC; i++)
         fwd_sel[i*SW +: SW] = rst ? '0 : fwd_raw[i];
   end

   always_comb begin
      id_load = id_valid && !stall && !flush[FL_IDEX];
      sb_d    = '0;
      for (int k = 1; k <= FWD_STAGES; k++) begin
         sb_d[k] = sb_q[k-1];
         if (br_taken && (k <= BR_STAGE))
            sb_d[k].valid = 1'b0;
      end
      if (id_load) begin
         sb_d[0].valid    = 1'b1;
         sb_d[0].rd       = RA_MAX'(id_rd);
         sb_d[0].regwrite = id_regwrite;
         sb_d[0].memread  = id_memread;
      end
      ex_rs_d     = id_load ? id_rs : '0;
      ex_used_d   = id_load ? id_rs_used : '0;
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sb_q        <= '0;
         ex_rs_q     <= '0;
         ex_used_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         sb_q        <= sb_d;
         ex_rs_q     <= ex_rs_d;
         ex_used_q   <= ex_used_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Parametrised forwarding, load-use interlock and branch-flush controller for the in-order pipelined core.
- Tracks up to FWD_STAGES in-flight producers behind EX in an internal scoreboard shift register.
- Drives per-source forward selects for the instruction in EX, stall enables for PC and IF/ID, per-boundary flush strobes, and a stall-cycle counter.
- Replaces the single-stage two-source forwarding unit; adds load-use stalls and configurable branch resolution.

Parameters:
- RA_W, 5, register address width; register 0 is hard-wired to zero.
- NUM_SRC, 2, source operands per instruction.
- FWD_STAGES, 2, stages after EX that can forward (s1 = EX/MEM … sF = MEM/WB, F = FWD_STAGES).
- LOAD_LAT, 1, extra stages before load data is forwardable. Legal range: 1+LOAD_LAT <= FWD_STAGES.
- BR_STAGE, 1, stage index where branches resolve (0 = EX, 1 = MEM).
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  NUM_SRC*RA_W  ID source addresses, source i at [i*RA_W +: RA_W]
- id_rs_used  in  NUM_SRC  source i is actually read
- id_rd  in  RA_W  ID destination
- id_regwrite  in  1  ID instruction writes rd
- id_memread  in  1  ID instruction is a load
- br_taken  in  1  branch at stage BR_STAGE is taken this cycle
- fwd_sel  out  NUM_SRC*SW  per EX source: 0 = register file, k = forward from stage sk; SW = clog2(FWD_STAGES+1)
- stall  out  1  hold PC and IF/ID; insert bubble into ID/EX
- flush  out  BR_STAGE+2  bit j kills pipeline register j (0 = IF/ID, 1 = ID/EX, 2 = EX/MEM)
- stall_cnt  out  CNT_W  stall cycles since reset

Behaviour:
- Scoreboard: entries s0 (EX) … sF, each holding {valid, rd, regwrite, memread}. A separate register holds ex_rs/ex_rs_used for the instruction in s0.
- On each clk, every entry s(k) moves to s(k+1), and s(F) retires.
- s0 loads the ID fields when id_valid & !stall & !flush[1]; otherwise s0 loads a bubble (valid=0).
- Forwarding (combinational from the registered state):
  - For EX source i, fwd_sel = the smallest k in 1..F such that s(k) is valid & regwrite, rd == rs_i, rd != 0, rs_used_i is set, and (!memread or k >= 1+LOAD_LAT).
  - If no stage matches, fwd_sel = 0. The youngest producer wins.
- Load-use stall (combinational):
  - stall = 1 if some used ID source matches a valid memread entry s(j) with j < LOAD_LAT, rd != 0.
  - The ID source must also match nothing younger that resolves first; the youngest match decides.
  - With LOAD_LAT=1 this gives exactly one bubble per load-use pair. With LOAD_LAT=2 the pair gets two bubbles back-to-back (the load at s0, then at s1).
- Branch flush:
  - When br_taken=1, flush is all ones for that cycle.
  - Entries s0 … s(BR_STAGE-1) are invalidated at the next edge, together with the incoming ID instruction.
  - flush overrides stall: stall is forced to 0 whenever br_taken=1.
- stall_cnt increments on each cycle with stall=1 and saturates at all ones.
- Reset, asynchronous:
  - All entries and ex_rs cleared; stall_cnt = 0.
  - Outputs while rst is high: fwd_sel = 0, stall = 0, flush = 0.
  - Reset asserted mid-stall drops stall immediately.
- Producers at sF are forwarded directly. Producers older than sF are the register file's responsibility (write-before-read).

Decomposition:
- Shared package: the scoreboard entry typedef {valid, rd, regwrite, memread}, the SW computation, and the flush bit-index constants (FL_IFID=0, FL_IDEX=1, FL_EXMEM=2).
- One natural sub-module: hazard_match, a combinational priority match of one source against the entry array, instantiated NUM_SRC times for forwarding and NUM_SRC times for stall detection.

Test Plan:
- Forward EX/MEM: add x5 issued, then add x6,x5,x5 the next cycle -> fwd_sel = {1,1}, stall = 0.
- Forward MEM/WB: x5 producer, one independent instruction, then a consumer reading x5 -> fwd_sel[0] = 2.
- Load-use: lw x7, then add x8,x7,x1 -> stall = 1 for exactly one cycle, stall_cnt 0->1; next cycle the consumer sees fwd_sel[0] = 2.
- x0 and unused sources: producer rd=0 with consumer rs=0, and a matching rs with rs_used=0 -> fwd_sel = 0, stall = 0.
- Branch during stall: br_taken on the same cycle as a load-use hit -> stall = 0, flush = 3'b111, s0 invalid on the next cycle, stall_cnt unchanged.
- Reset mid-stall: assert rst while stall = 1 -> stall = 0 asynchronously, stall_cnt = 0; after release the first consumer sees fwd_sel = 0.
